// File: rtl/lsu.sv
// lsu: load/store unit between the execute stage and the data memory.
//
// Accepts one load or store at a time, drives dmem with word-aligned
// addresses and lane-aligned byte enables/data, splits accesses that cross
// a word boundary into two sequential word accesses, and returns assembled,
// sign/zero-extended load data on a one-cycle response pulse.
//
// Ports:
//   clk, rst_n          clock (rising edge), asynchronous active-low reset
//   req_valid/req_ready request handshake; a request is accepted on a rising
//                       edge where both are 1 (req_ready is 1 only in IDLE)
//   req_we              1 = store, 0 = load
//   req_funct3          RISC-V funct3 (LB/LH/LW/LBU/LHU, SB/SH/SW)
//   req_addr            byte address (bits above ADDR_W ignored)
//   req_wdata           store data, right-aligned
//   resp_valid          one-cycle completion pulse, no backpressure
//   resp_rdata          extended load data; 0 for stores and errors
//   resp_err            illegal funct3, qualified by resp_valid
//   dmem_en/we/addr/din dmem request, decoded from state + captured request
//   dmem_dout           dmem read data, combinational from dmem_en/dmem_addr
module lsu #(
  parameter int ADDR_W = 14
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic              req_we,
  input  logic [2:0]        req_funct3,
  input  logic [31:0]       req_addr,
  input  logic [31:0]       req_wdata,
  output logic              resp_valid,
  output logic [31:0]       resp_rdata,
  output logic              resp_err,
  output logic              dmem_en,
  output logic [3:0]        dmem_we,
  output logic [ADDR_W-1:0] dmem_addr,
  output logic [31:0]       dmem_din,
  input  logic [31:0]       dmem_dout
);

  typedef enum logic [1:0] {IDLE, ACC0, ACC1, RESP} state_e;

  state_e              state_q, state_d;
  logic                we_q;
  logic                err_q;
  logic [2:0]          funct3_q;
  logic [ADDR_W-1:0]   addr_q;
  logic [31:0]         wdata_q;
  logic [31:0]         lo_q;
  logic [31:0]         hi_q;

  logic                illegal_req;
  logic [1:0]          off;
  logic [3:0]          mask;
  logic                split;
  logic [63:0]         wdata_sh;
  logic [7:0]          mask_sh;
  logic [ADDR_W-3:0]   word_idx;
  logic [ADDR_W-3:0]   word_inc;
  logic [31:0]         ld_word;
  logic [31:0]         ld_data;
  logic [31:0]         unused_addr_hi;

  // Request address bits above the dmem range are intentionally dropped.
  assign unused_addr_hi = req_addr;

  // Loads reject 011/110/111; stores reject 011 and every 1xx.
  assign illegal_req = (req_funct3 == 3'b011) || (req_funct3[2:1] == 2'b11) ||
                       (req_we && req_funct3[2]);

  assign off      = addr_q[1:0];
  assign word_idx = addr_q[ADDR_W-1:2];
  // Second word wraps modulo the dmem word count.
  assign word_inc = word_idx + (ADDR_W-2)'(1);

  always_comb begin
    mask  = 4'b1111;
    split = 1'b0;
    case (funct3_q[1:0])
      2'b00:   mask = 4'b0001;
      2'b01: begin
        mask  = 4'b0011;
        split = (off == 2'd3);
      end
      default: begin
        mask  = 4'b1111;
        split = (off != 2'd0);
      end
    endcase
  end

  // 64-bit lane view: low half goes to the first word, high half to the next.
  assign wdata_sh = {32'b0, wdata_q} << {off, 3'b000};
  assign mask_sh  = {4'b0, mask} << off;
  assign ld_word  = 32'({hi_q, lo_q} >> {off, 3'b000});

  always_comb begin
    ld_data = 32'b0;
    case (funct3_q)
      3'b000:  ld_data = {{24{ld_word[7]}}, ld_word[7:0]};
      3'b001:  ld_data = {{16{ld_word[15]}}, ld_word[15:0]};
      3'b010:  ld_data = ld_word;
      3'b100:  ld_data = {24'b0, ld_word[7:0]};
      3'b101:  ld_data = {16'b0, ld_word[15:0]};
      default: ld_data = 32'b0;
    endcase
  end

  always_comb begin
    state_d    = state_q;
    req_ready  = 1'b0;
    resp_valid = 1'b0;
    resp_rdata = 32'b0;
    resp_err   = 1'b0;
    dmem_en    = 1'b0;
    dmem_we    = 4'b0;
    dmem_addr  = '0;
    dmem_din   = 32'b0;
    case (state_q)
      IDLE: begin
        req_ready = 1'b1;
        if (req_valid) state_d = illegal_req ? RESP : ACC0;
      end
      ACC0: begin
        dmem_en   = 1'b1;
        dmem_addr = {word_idx, 2'b00};
        if (we_q) begin
          dmem_we  = mask_sh[3:0];
          dmem_din = wdata_sh[31:0];
        end
        state_d = split ? ACC1 : RESP;
      end
      ACC1: begin
        dmem_en   = 1'b1;
        dmem_addr = {word_inc, 2'b00};
        if (we_q) begin
          dmem_we  = mask_sh[7:4];
          dmem_din = wdata_sh[63:32];
        end
        state_d = RESP;
      end
      RESP: begin
        resp_valid = 1'b1;
        resp_err   = err_q;
        resp_rdata = (we_q || err_q) ? 32'b0 : ld_data;
        state_d    = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= IDLE;
      we_q     <= 1'b0;
      err_q    <= 1'b0;
      funct3_q <= 3'b0;
      addr_q   <= '0;
      wdata_q  <= 32'b0;
      lo_q     <= 32'b0;
      hi_q     <= 32'b0;
    end else begin
      state_q <= state_d;
      case (state_q)
        IDLE: begin
          if (req_valid) begin
            we_q     <= req_we;
            err_q    <= illegal_req;
            funct3_q <= req_funct3;
            addr_q   <= req_addr[ADDR_W-1:0];
            wdata_q  <= req_wdata;
            // hi word must read as zero for non-split loads
            lo_q     <= 32'b0;
            hi_q     <= 32'b0;
          end
        end
        ACC0: if (!we_q) lo_q <= dmem_dout;
        ACC1: if (!we_q) hi_q <= dmem_dout;
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_lsu.sv
// Directed testbench for lsu with a byte-enabled word memory model.
module tb_lsu;

  logic        clk;
  logic        rst_n;
  logic        req_valid;
  logic        req_ready;
  logic        req_we;
  logic [2:0]  req_funct3;
  logic [31:0] req_addr;
  logic [31:0] req_wdata;
  logic        resp_valid;
  logic [31:0] resp_rdata;
  logic        resp_err;
  logic        dmem_en;
  logic [3:0]  dmem_we;
  logic [13:0] dmem_addr;
  logic [31:0] dmem_din;
  logic [31:0] dmem_dout;

  int tests;
  int fails;

  // results of the last transaction
  logic        r_got;
  logic [31:0] r_data;
  logic        r_err;
  int          r_lat;
  int          acc_n;
  logic [13:0] acc_addr [4];
  logic [3:0]  acc_we   [4];
  logic [31:0] acc_din  [4];

  logic [31:0] mem [4096];

  lsu #(.ADDR_W(14)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .req_valid  (req_valid),
    .req_ready  (req_ready),
    .req_we     (req_we),
    .req_funct3 (req_funct3),
    .req_addr   (req_addr),
    .req_wdata  (req_wdata),
    .resp_valid (resp_valid),
    .resp_rdata (resp_rdata),
    .resp_err   (resp_err),
    .dmem_en    (dmem_en),
    .dmem_we    (dmem_we),
    .dmem_addr  (dmem_addr),
    .dmem_din   (dmem_din),
    .dmem_dout  (dmem_dout)
  );

  // clock / memory model
  initial clk = 1'b0;
  always #5 clk = ~clk;

  assign dmem_dout = mem[dmem_addr[13:2]];

  always @(posedge clk) begin
    if (dmem_en) begin
      for (int b = 0; b < 4; b++) begin
        if (dmem_we[b]) mem[dmem_addr[13:2]][8*b +: 8] <= dmem_din[8*b +: 8];
      end
    end
  end

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  // drive one request, wait for its response, record dmem accesses
  task automatic do_req(input logic we, input logic [2:0] f3,
                        input logic [31:0] a, input logic [31:0] d);
    @(negedge clk);
    req_valid  = 1'b1;
    req_we     = we;
    req_funct3 = f3;
    req_addr   = a;
    req_wdata  = d;
    acc_n      = 0;
    r_got      = 1'b0;
    r_data     = 32'b0;
    r_err      = 1'b0;
    @(posedge clk);
    #1 req_valid = 1'b0;
    r_lat = 1;
    for (int i = 0; i < 8 && !r_got; i++) begin
      @(negedge clk);
      if (dmem_en && acc_n < 4) begin
        acc_addr[acc_n] = dmem_addr;
        acc_we[acc_n]   = dmem_we;
        acc_din[acc_n]  = dmem_din;
        acc_n++;
      end
      if (resp_valid) begin
        r_got  = 1'b1;
        r_data = resp_rdata;
        r_err  = resp_err;
      end else begin
        @(posedge clk);
        r_lat++;
      end
    end
    check("resp_seen", r_got, 1);
  endtask

  initial begin
    tests      = 0;
    fails      = 0;
    rst_n      = 1'b0;
    req_valid  = 1'b0;
    req_we     = 1'b0;
    req_funct3 = 3'b0;
    req_addr   = 32'b0;
    req_wdata  = 32'b0;

    // reset values
    #12;
    check("rst_req_ready", req_ready, 1);
    check("rst_resp_valid", resp_valid, 0);
    check("rst_resp_rdata", resp_rdata, 0);
    check("rst_resp_err", resp_err, 0);
    check("rst_dmem_en", dmem_en, 0);
    check("rst_dmem_we", dmem_we, 0);
    check("rst_dmem_addr", dmem_addr, 0);
    check("rst_dmem_din", dmem_din, 0);
    @(negedge clk);
    rst_n = 1'b1;

    // aligned store word
    do_req(1'b1, 3'b010, 32'h10, 32'hDEADBEEF);
    check("sw_lat", r_lat, 2);
    check("sw_nacc", acc_n, 1);
    check("sw_addr", acc_addr[0], 14'h10);
    check("sw_we", acc_we[0], 4'b1111);
    check("sw_din", acc_din[0], 32'hDEADBEEF);
    check("sw_rdata", r_data, 0);
    check("sw_err", r_err, 0);
    check("sw_mem", mem[4], 32'hDEADBEEF);

    // aligned load word
    do_req(1'b0, 3'b010, 32'h10, 32'h0);
    check("lw_lat", r_lat, 2);
    check("lw_we", acc_we[0], 4'b0000);
    check("lw_rdata", r_data, 32'hDEADBEEF);
    check("lw_err", r_err, 0);

    // store byte at offset 1, then reload with ignored high address bits
    do_req(1'b1, 3'b000, 32'h11, 32'h1234565A);
    check("sb_we", acc_we[0], 4'b0010);
    check("sb_din", acc_din[0], 32'h34565A00);
    do_req(1'b0, 3'b010, 32'h0001_0010, 32'h0);
    check("lw_hiaddr_rdata", r_data, 32'hDEAD5AEF);

    // byte extension
    do_req(1'b1, 3'b010, 32'h0, 32'h80FF7F01);
    do_req(1'b0, 3'b000, 32'h2, 32'h0);
    check("lb2_rdata", r_data, 32'hFFFFFFFF);
    do_req(1'b0, 3'b100, 32'h2, 32'h0);
    check("lbu2_rdata", r_data, 32'h000000FF);
    do_req(1'b0, 3'b000, 32'h3, 32'h0);
    check("lb3_rdata", r_data, 32'hFFFFFF80);
    do_req(1'b0, 3'b101, 32'h0, 32'h0);
    check("lhu0_rdata", r_data, 32'h00007F01);

    // split halfword load
    do_req(1'b1, 3'b010, 32'h0, 32'h11223344);
    do_req(1'b1, 3'b010, 32'h4, 32'h55667788);
    do_req(1'b0, 3'b001, 32'h3, 32'h0);
    check("lh3_lat", r_lat, 3);
    check("lh3_nacc", acc_n, 2);
    check("lh3_addr0", acc_addr[0], 14'h0);
    check("lh3_addr1", acc_addr[1], 14'h4);
    check("lh3_rdata", r_data, 32'hFFFF8811);
    do_req(1'b0, 3'b101, 32'h3, 32'h0);
    check("lhu3_rdata", r_data, 32'h00008811);

    // split store word over zeroed words
    do_req(1'b1, 3'b010, 32'h4, 32'h0);
    do_req(1'b1, 3'b010, 32'h8, 32'h0);
    do_req(1'b1, 3'b010, 32'h6, 32'hAABBCCDD);
    check("sw6_lat", r_lat, 3);
    check("sw6_we0", acc_we[0], 4'b1100);
    check("sw6_we1", acc_we[1], 4'b0011);
    check("sw6_din0", acc_din[0], 32'hCCDD0000);
    check("sw6_din1", acc_din[1], 32'h0000AABB);
    check("sw6_mem1", mem[1], 32'hCCDD0000);
    check("sw6_mem2", mem[2], 32'h0000AABB);

    // split load wrapping past the top of dmem
    do_req(1'b1, 3'b010, 32'h3FFC, 32'h44332211);
    do_req(1'b1, 3'b010, 32'h0, 32'h88776655);
    do_req(1'b0, 3'b010, 32'h3FFE, 32'h0);
    check("wrap_addr0", acc_addr[0], 14'h3FFC);
    check("wrap_addr1", acc_addr[1], 14'h0000);
    check("wrap_rdata", r_data, 32'h66554433);

    // illegal funct3
    do_req(1'b0, 3'b011, 32'h10, 32'h0);
    check("ill_ld_lat", r_lat, 1);
    check("ill_ld_err", r_err, 1);
    check("ill_ld_nacc", acc_n, 0);
    check("ill_ld_rdata", r_data, 0);
    do_req(1'b1, 3'b100, 32'h10, 32'hFFFFFFFF);
    check("ill_st_lat", r_lat, 1);
    check("ill_st_err", r_err, 1);
    check("ill_st_nacc", acc_n, 0);
    check("ill_st_mem", mem[4], 32'hDEAD5AEF);

    // reset during ACC1 of a split load
    do_req(1'b1, 3'b010, 32'h0, 32'h11223344);
    @(negedge clk);
    req_valid  = 1'b1;
    req_we     = 1'b0;
    req_funct3 = 3'b001;
    req_addr   = 32'h3;
    @(posedge clk);
    #1 req_valid = 1'b0;
    @(negedge clk);
    check("abort_acc0_addr", dmem_addr, 14'h0);
    @(negedge clk);
    check("abort_acc1_addr", dmem_addr, 14'h4);
    rst_n = 1'b0;
    #1;
    check("abort_ready", req_ready, 1);
    check("abort_en", dmem_en, 0);
    check("abort_resp", resp_valid, 0);
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      check("abort_hold_resp", resp_valid, 0);
      check("abort_hold_en", dmem_en, 0);
    end
    rst_n = 1'b1;
    do_req(1'b0, 3'b010, 32'h10, 32'h0);
    check("post_abort_lat", r_lat, 2);
    check("post_abort_rdata", r_data, 32'hDEAD5AEF);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
